// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundles the two requester ports, the memory port and the statistics output of
// vram_arbiter.
//   master : the requesters and the memory model (drives requests and rdata)
//   slave  : the arbiter (drives grants, the registered memory command, read data and valids)
// Requester side : req_x, addr_x[18:0], dwrite_x[15:0], wr_x -> gnt_x, rvalid_x
// Memory side    : addr[18:0], dwrite[15:0], wr, en -> rdata[15:0]; rdata_o mirrors rdata
`timescale 1ns/1ps
interface vram_arbiter_if;
  logic        req_a;
  logic        req_b;
  logic [18:0] addr_a;
  logic [18:0] addr_b;
  logic [15:0] dwrite_a;
  logic [15:0] dwrite_b;
  logic        wr_a;
  logic        wr_b;
  logic        gnt_a;
  logic        gnt_b;
  logic [18:0] addr;
  logic [15:0] dwrite;
  logic        wr;
  logic        en;
  logic [15:0] rdata;
  logic [15:0] rdata_o;
  logic        rvalid_a;
  logic        rvalid_b;
  logic [15:0] stall_cnt;

  modport master (
    output req_a, req_b, addr_a, addr_b, dwrite_a, dwrite_b, wr_a, wr_b, rdata,
    input  gnt_a, gnt_b, addr, dwrite, wr, en, rdata_o, rvalid_a, rvalid_b, stall_cnt
  );

  modport slave (
    input  req_a, req_b, addr_a, addr_b, dwrite_a, dwrite_b, wr_a, wr_b, rdata,
    output gnt_a, gnt_b, addr, dwrite, wr, en, rdata_o, rvalid_a, rvalid_b, stall_cnt
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: two-requester arbiter for a single-port VRAM with bounded bursts.
// Ownership alternates on ties; an owner keeps the port for up to BURST_MAX transfers while the
// other side waits. The memory command (addr/dwrite/wr/en) is registered one cycle after the
// transfer; read ownership is tracked through an RD_LAT-deep tag pipe to steer rvalid_a/rvalid_b.
// Ports:
//   clk  : system clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : vram_arbiter_if.slave (requester ports, memory port, stall_cnt)
// Parameters: BURST_MAX (1..255), RD_LAT (1..4).
// Optional feature: define VRAM_ARBITER_STATS_EN to build the stall_cnt contention counter;
// otherwise stall_cnt is tied to zero.
`timescale 1ns/1ps
module vram_arbiter #(
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned RD_LAT    = 1
) (
  input logic           clk,
  input logic           rstn,
  vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle = 2'd0, StOwnA = 2'd1, StOwnB = 2'd2} state_e;

  localparam logic [7:0] RunMax = 8'(BURST_MAX - 1);

  state_e      state_q, state_d;
  logic        last_b_q;     // 1: B was the most recent owner
  logic [7:0]  run_q, run_d;
  logic        gnt_a, gnt_b;
  logic        xfer_a, xfer_b;
  logic        en_q, wr_q;
  logic [18:0] addr_q;
  logic [15:0] dwrite_q;
  logic        rd_a_q, rd_b_q; // read tag travelling with the en cycle
  logic [RD_LAT-1:0] rv_a_q, rv_b_q;

  assign gnt_a  = (state_q == StOwnA);
  assign gnt_b  = (state_q == StOwnB);
  assign xfer_a = bus.req_a && gnt_a;
  assign xfer_b = bus.req_b && gnt_b;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_a && bus.req_b) state_d = last_b_q ? StOwnA : StOwnB;
        else if (bus.req_a)         state_d = StOwnA;
        else if (bus.req_b)         state_d = StOwnB;
      end
      StOwnA: begin
        if (!bus.req_a)                       state_d = bus.req_b ? StOwnB : StIdle;
        else if (bus.req_b && run_q == RunMax) state_d = StOwnB;
      end
      StOwnB: begin
        if (!bus.req_b)                       state_d = bus.req_a ? StOwnA : StIdle;
        else if (bus.req_a && run_q == RunMax) state_d = StOwnA;
      end
      default: state_d = StIdle;
    endcase
  end

  // Run length restarts on every ownership change; it saturates so an uncontested owner stays put.
  always_comb begin
    run_d = run_q;
    if (state_d != state_q)                   run_d = '0;
    else if ((xfer_a || xfer_b) && run_q != RunMax) run_d = run_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      last_b_q <= 1'b1;
      run_q    <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      if (state_d == StOwnA)      last_b_q <= 1'b0;
      else if (state_d == StOwnB) last_b_q <= 1'b1;
    end
  end

  // Registered memory command; addr/dwrite hold when there is no transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      dwrite_q <= '0;
      rd_a_q   <= 1'b0;
      rd_b_q   <= 1'b0;
    end else if (xfer_a) begin
      en_q     <= 1'b1;
      wr_q     <= bus.wr_a;
      addr_q   <= bus.addr_a;
      dwrite_q <= bus.dwrite_a;
      rd_a_q   <= !bus.wr_a;
      rd_b_q   <= 1'b0;
    end else if (xfer_b) begin
      en_q     <= 1'b1;
      wr_q     <= bus.wr_b;
      addr_q   <= bus.addr_b;
      dwrite_q <= bus.dwrite_b;
      rd_a_q   <= 1'b0;
      rd_b_q   <= !bus.wr_b;
    end else begin
      en_q   <= 1'b0;
      wr_q   <= 1'b0;
      rd_a_q <= 1'b0;
      rd_b_q <= 1'b0;
    end
  end

  // Tag pipe: stage RD_LAT-1 lines up with the cycle the memory returns data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rv_a_q <= '0;
      rv_b_q <= '0;
    end else begin
      rv_a_q[0] <= rd_a_q;
      rv_b_q[0] <= rd_b_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        rv_a_q[i] <= rv_a_q[i-1];
        rv_b_q[i] <= rv_b_q[i-1];
      end
    end
  end

`ifdef VRAM_ARBITER_STATS_EN
  logic [15:0] stall_q;
  logic        stall;
  assign stall = (bus.req_a && !gnt_a) || (bus.req_b && !gnt_b);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                             stall_q <= '0;
    else if (stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.en       = en_q;
  assign bus.wr       = wr_q;
  assign bus.addr     = addr_q;
  assign bus.dwrite   = dwrite_q;
  assign bus.rdata_o  = bus.rdata;
  assign bus.rvalid_a = rv_a_q[RD_LAT-1];
  assign bus.rvalid_b = rv_b_q[RD_LAT-1];

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter.
// u_dut uses BURST_MAX=4, RD_LAT=2; u_dut1 uses BURST_MAX=1, RD_LAT=1 for strict alternation.
// Inputs change and outputs are sampled 1 ns after each rising edge ("window k" = cycle k).
`timescale 1ns/1ps
module tb_vram_arbiter;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  vram_arbiter_if bus ();
  vram_arbiter_if bus1 ();

  vram_arbiter #(.BURST_MAX(4), .RD_LAT(2)) u_dut  (.clk(clk), .rstn(rstn), .bus(bus));
  vram_arbiter #(.BURST_MAX(1), .RD_LAT(1)) u_dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

  typedef struct packed {
    logic        wr;
    logic [18:0] addr;
    logic [15:0] dwrite;
  } cmd_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  cmd_t exp_cmd_q[$];
  logic exp_rd_q[$];     // 1: read owned by B
  logic [1:0] exp_gnt_q[$]; // {gnt_a, gnt_b}

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_a = 0; bus.req_b = 0; bus.wr_a = 0; bus.wr_b = 0;
    bus.addr_a = '0; bus.addr_b = '0; bus.dwrite_a = '0; bus.dwrite_b = '0; bus.rdata = '0;
    bus1.req_a = 0; bus1.req_b = 0; bus1.wr_a = 0; bus1.wr_b = 0;
    bus1.addr_a = '0; bus1.addr_b = '0; bus1.dwrite_a = '0; bus1.dwrite_b = '0; bus1.rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    exp_cmd_q.delete();
    exp_rd_q.delete();
    exp_gnt_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt: got %b want 00", {bus.gnt_a, bus.gnt_b});
    end
    n_checks++;
    if ({bus.en, bus.wr} !== 2'b00) begin
      n_fail++; $display("FAIL reset_en_wr: got %b want 00", {bus.en, bus.wr});
    end
    n_checks++;
    if (bus.addr !== 19'h0 || bus.dwrite !== 16'h0) begin
      n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", bus.addr, bus.dwrite);
    end
    n_checks++;
    if ({bus.rvalid_a, bus.rvalid_b} !== 2'b00) begin
      n_fail++; $display("FAIL reset_rvalid: got %b want 00", {bus.rvalid_a, bus.rvalid_b});
    end
    n_checks++;
    if (bus.stall_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cnt);
    end
    step();
    rstn = 1'b1;
    step();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b, bus.en} !== 3'b000) begin
      n_fail++; $display("FAIL reset_idle: got %b want 000", {bus.gnt_a, bus.gnt_b, bus.en});
    end
  endtask

  task automatic test_single_write();
    cmd_t got, expc;
    bus.req_a = 1; bus.wr_a = 1; bus.addr_a = 19'h00010; bus.dwrite_a = 16'hABCD;
    exp_cmd_q.push_back({1'b1, 19'h00010, 16'hABCD});
    step(); // cycle 1
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
      n_fail++; $display("FAIL single_gnt: got %b want 10", {bus.gnt_a, bus.gnt_b});
    end
    n_checks++;
    if (bus.en !== 1'b0) begin
      n_fail++; $display("FAIL single_en_early: got %b want 0", bus.en);
    end
    step(); // cycle 2
    n_checks++;
    if (bus.en !== 1'b1) begin
      n_fail++; $display("FAIL single_en: got %b want 1", bus.en);
    end else begin
      got  = {bus.wr, bus.addr, bus.dwrite};
      expc = exp_cmd_q.pop_front();
      n_checks++;
      if (got !== expc) begin
        n_fail++; $display("FAIL single_cmd: got %h want %h", got, expc);
      end
    end
    bus.req_a = 0;
    step(); // cycle 3: no transfer, addr/dwrite hold
    n_checks++;
    if (bus.en !== 1'b0 || bus.wr !== 1'b0 || bus.addr !== 19'h00010 || bus.dwrite !== 16'hABCD)
    begin
      n_fail++;
      $display("FAIL single_hold: got en=%b wr=%b addr=%h d=%h want 0 0 00010 abcd",
               bus.en, bus.wr, bus.addr, bus.dwrite);
    end
    step();
  endtask

  task automatic test_burst();
    cmd_t got, expc;
    logic [1:0] eg;
    do_reset();
    bus.req_a = 1; bus.wr_a = 1; bus.addr_a = 19'h11111; bus.dwrite_a = 16'h1111;
    bus.req_b = 1; bus.wr_b = 1; bus.addr_b = 19'h22222; bus.dwrite_b = 16'h2222;
    for (int i = 0; i < 16; i++) begin
      if (((i / 4) % 2) == 0) begin
        exp_gnt_q.push_back(2'b10); exp_cmd_q.push_back({1'b1, 19'h11111, 16'h1111});
      end else begin
        exp_gnt_q.push_back(2'b01); exp_cmd_q.push_back({1'b1, 19'h22222, 16'h2222});
      end
    end
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k <= 16) begin
        eg = exp_gnt_q.pop_front();
        n_checks++;
        if ({bus.gnt_a, bus.gnt_b} !== eg) begin
          n_fail++; $display("FAIL burst_gnt c%0d: got %b want %b", k, {bus.gnt_a, bus.gnt_b}, eg);
        end
      end
      if (bus.en === 1'b1) begin
        n_checks++;
        if (exp_cmd_q.size() == 0) begin
          n_fail++; $display("FAIL burst_extra_en c%0d: got en=1 want 0", k);
        end else begin
          got  = {bus.wr, bus.addr, bus.dwrite};
          expc = exp_cmd_q.pop_front();
          if (got !== expc) begin
            n_fail++; $display("FAIL burst_cmd c%0d: got %h want %h", k, got, expc);
          end
        end
      end
      if ({bus.rvalid_a, bus.rvalid_b} !== 2'b00) begin
        n_checks++; n_fail++;
        $display("FAIL burst_write_rvalid c%0d: got %b want 00", k, {bus.rvalid_a, bus.rvalid_b});
      end
      if (k == 17) begin
        bus.req_a = 0; bus.req_b = 0;
      end
    end
    step();
    n_checks++;
    if (bus.en !== 1'b0 || exp_cmd_q.size() != 0) begin
      n_fail++; $display("FAIL burst_drain: got en=%b left=%0d want 0 0", bus.en, exp_cmd_q.size());
    end
    step();
  endtask

  task automatic test_read_b();
    cmd_t got, expc;
    logic erv, tag;
    bus.req_b = 1; bus.wr_b = 0; bus.addr_b = 19'h00100; bus.dwrite_b = 16'h0;
    for (int k = 1; k <= 9; k++) begin
      step();
      erv = (k >= 4 && k <= 6);
      n_checks++;
      if ({bus.rvalid_a, bus.rvalid_b} !== {1'b0, erv}) begin
        n_fail++;
        $display("FAIL read_rvalid c%0d: got %b want %b", k, {bus.rvalid_a, bus.rvalid_b},
                 {1'b0, erv});
      end
      if (bus.rvalid_b === 1'b1 && exp_rd_q.size() != 0) begin
        tag = exp_rd_q.pop_front();
        n_checks++;
        if (tag !== 1'b1 || bus.rdata_o !== bus.rdata) begin
          n_fail++;
          $display("FAIL read_data c%0d: got tag=%b data=%h want 1 %h", k, tag, bus.rdata_o,
                   bus.rdata);
        end
      end
      if (bus.en === 1'b1) begin
        n_checks++;
        if (exp_cmd_q.size() == 0) begin
          n_fail++; $display("FAIL read_extra_en c%0d: got en=1 want 0", k);
        end else begin
          got  = {bus.wr, bus.addr, bus.dwrite};
          expc = exp_cmd_q.pop_front();
          if (got !== expc) begin
            n_fail++; $display("FAIL read_cmd c%0d: got %h want %h", k, got, expc);
          end
        end
      end
      bus.rdata = 16'($urandom);
      if (k <= 3) begin
        bus.addr_b = 19'h00100 + 19'(k);
        exp_cmd_q.push_back({1'b0, 19'h00100 + 19'(k), 16'h0});
        exp_rd_q.push_back(1'b1);
      end else begin
        bus.req_b = 0;
      end
    end
    n_checks++;
    if (exp_rd_q.size() != 0 || exp_cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL read_lost: got %0d/%0d pending want 0/0", exp_rd_q.size(), exp_cmd_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    bus.req_a = 1; bus.wr_a = 0; bus.addr_a = 19'h00200;
    step(); // cycle 1
    step(); // cycle 2: read on the memory port
    bus.req_a = 0;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b, bus.en, bus.wr, bus.rvalid_a, bus.rvalid_b} !== 6'b0 ||
        bus.addr !== 19'h0 || bus.dwrite !== 16'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b addr=%h want 000000 addr=0",
               {bus.gnt_a, bus.gnt_b, bus.en, bus.wr, bus.rvalid_a, bus.rvalid_b}, bus.addr);
    end
    step();
    rstn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if ({bus.rvalid_a, bus.rvalid_b, bus.en} !== 3'b000) begin
        n_fail++;
        $display("FAIL midreset_rvalid c%0d: got %b want 000", k,
                 {bus.rvalid_a, bus.rvalid_b, bus.en});
      end
    end
    bus.req_a = 1; bus.wr_a = 1; bus.req_b = 1; bus.wr_b = 1;
    step();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
      n_fail++; $display("FAIL midreset_tie: got %b want 10", {bus.gnt_a, bus.gnt_b});
    end
    bus.req_a = 0; bus.req_b = 0;
    step();
    step();
  endtask

  task automatic test_handoff();
    bus.req_a = 1; bus.wr_a = 1; bus.req_b = 0; bus.wr_b = 1;
    step();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
      n_fail++; $display("FAIL handoff_own_a: got %b want 10", {bus.gnt_a, bus.gnt_b});
    end
    bus.req_b = 1;
    step();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
      n_fail++; $display("FAIL handoff_hold_a: got %b want 10", {bus.gnt_a, bus.gnt_b});
    end
    bus.req_a = 0;
    step();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b01) begin
      n_fail++; $display("FAIL handoff_to_b: got %b want 01", {bus.gnt_a, bus.gnt_b});
    end
    bus.req_b = 0;
    step();
    step();
  endtask

  task automatic test_stats();
    logic [15:0] es;
`ifdef VRAM_ARBITER_STATS_EN
    es = 16'd10;
`else
    es = 16'd0;
`endif
    do_reset();
    bus.req_a = 1; bus.wr_a = 1; bus.req_b = 1; bus.wr_b = 1;
    for (int k = 1; k <= 10; k++) step();
    bus.req_a = 0; bus.req_b = 0;
    n_checks++;
    if (bus.stall_cnt !== es) begin
      n_fail++; $display("FAIL stats_count: got %0d want %0d", bus.stall_cnt, es);
    end
    step();
    step();
    n_checks++;
    if (bus.stall_cnt !== es) begin
      n_fail++; $display("FAIL stats_hold: got %0d want %0d", bus.stall_cnt, es);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] eg;
    do_reset();
    bus1.req_a = 1; bus1.wr_a = 1; bus1.req_b = 1; bus1.wr_b = 1;
    for (int i = 0; i < 8; i++) exp_gnt_q.push_back((i % 2 == 0) ? 2'b10 : 2'b01);
    for (int k = 1; k <= 8; k++) begin
      step();
      eg = exp_gnt_q.pop_front();
      n_checks++;
      if ({bus1.gnt_a, bus1.gnt_b} !== eg) begin
        n_fail++; $display("FAIL alt_gnt c%0d: got %b want %b", k, {bus1.gnt_a, bus1.gnt_b}, eg);
      end
    end
    bus1.req_a = 0; bus1.req_b = 0;
    step();
    step();
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    step();
    test_reset();
    test_single_write();
    test_burst();
    test_read_b();
    test_reset_mid_read();
    test_handoff();
    test_stats();
    test_alternate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
